// File: rtl/sc_lsu.sv
// Load/store unit for the sc_rrv core: one RV32I load/store at a time, traps
// illegal/misaligned accesses before memory, returns extended load data.
module sc_lsu #(
    parameter int unsigned D_MEM_SIZE = 4096,
    parameter int unsigned ADDR_W     = $clog2(D_MEM_SIZE)
) (
    input  logic              Clk,
    input  logic              Rst_N,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic              ReqWr,
    input  logic [2:0]        ReqFunct3,
    input  logic [ADDR_W-1:0] ReqAddr,
    input  logic [31:0]       ReqWrData,
    output logic              RspValid,
    input  logic              RspReady,
    output logic [31:0]       RspData,
    output logic              RspErr,
    output logic [ADDR_W-1:0] DMemAddress,
    output logic [31:0]       DMemData,
    output logic [3:0]        DMemByteEn,
    output logic              DMemWrEn,
    output logic              DMemRdEn,
    input  logic [31:0]       DMemRspData
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RSP    = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              req_wr;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [31:0]       rsp_data, rsp_data_nxt;
    logic              rsp_err, rsp_err_nxt;

    logic              accept;
    logic              illegal;
    logic              misaligned;
    logic [3:0]        byte_en;
    logic [31:0]       lane_mask;
    logic [31:0]       load_ext;

    assign accept      = ReqValid && (state == IDLE);
    assign ReqReady    = (state == IDLE);
    assign RspValid    = (state == RSP);
    assign RspData     = rsp_data;
    assign RspErr      = rsp_err;
    assign DMemAddress = req_addr;

    // Legality is judged on the live request fields so a trap never reaches ACCESS
    always_comb begin
        illegal    = (ReqFunct3 == 3'b011) || (ReqFunct3[2:1] == 2'b11)
                     || (ReqWr && ReqFunct3[2]);
        misaligned = ((ReqFunct3[1:0] == 2'b01) && ReqAddr[0])
                     || ((ReqFunct3[1:0] == 2'b10) && (ReqAddr[1:0] != 2'b00));
    end

    // Size decode from the registered request
    always_comb begin
        case (req_funct3[1:0])
            2'b00:   byte_en = 4'b0001;
            2'b01:   byte_en = 4'b0011;
            default: byte_en = 4'b1111;
        endcase
        lane_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    end

    always_comb begin
        case (req_funct3)
            3'b000:  load_ext = {{24{DMemRspData[7]}}, DMemRspData[7:0]};
            3'b100:  load_ext = {24'd0, DMemRspData[7:0]};
            3'b001:  load_ext = {{16{DMemRspData[15]}}, DMemRspData[15:0]};
            3'b101:  load_ext = {16'd0, DMemRspData[15:0]};
            default: load_ext = DMemRspData;
        endcase
    end

    // Next state, response capture and memory strobes
    always_comb begin
        state_nxt    = state;
        rsp_data_nxt = rsp_data;
        rsp_err_nxt  = rsp_err;
        DMemWrEn     = 1'b0;
        DMemRdEn     = 1'b0;
        DMemByteEn   = 4'b0000;
        DMemData     = 32'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (illegal || misaligned) begin
                        state_nxt    = RSP;
                        rsp_data_nxt = 32'd0;
                        rsp_err_nxt  = 1'b1;
                    end else begin
                        state_nxt = ACCESS;
                    end
                end
            end
            ACCESS: begin
                DMemByteEn   = byte_en;
                DMemData     = req_wdata & lane_mask;
                DMemWrEn     = req_wr;
                DMemRdEn     = !req_wr;
                state_nxt    = RSP;
                rsp_data_nxt = req_wr ? 32'd0 : load_ext;
                rsp_err_nxt  = 1'b0;
            end
            RSP: begin
                if (RspReady) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state      <= IDLE;
            req_wr     <= 1'b0;
            req_funct3 <= 3'd0;
            req_addr   <= '0;
            req_wdata  <= 32'd0;
            rsp_data   <= 32'd0;
            rsp_err    <= 1'b0;
        end else begin
            state    <= state_nxt;
            rsp_data <= rsp_data_nxt;
            rsp_err  <= rsp_err_nxt;
            if (accept) begin
                req_wr     <= ReqWr;
                req_funct3 <= ReqFunct3;
                req_addr   <= ReqAddr;
                req_wdata  <= ReqWrData;
            end
        end
    end

endmodule

// File: tb/tb_sc_lsu.sv
// Randomized bench for sc_lsu: byte-array memory on the DMem port and a
// reference memory/decoder model that predicts every response.
module tb_sc_lsu;

    localparam int unsigned MEM_SIZE = 4096;
    localparam int unsigned AW       = 12;

    logic          Clk = 1'b0;
    logic          Rst_N;
    logic          ReqValid;
    logic          ReqReady;
    logic          ReqWr;
    logic [2:0]    ReqFunct3;
    logic [AW-1:0] ReqAddr;
    logic [31:0]   ReqWrData;
    logic          RspValid;
    logic          RspReady;
    logic [31:0]   RspData;
    logic          RspErr;
    logic [AW-1:0] DMemAddress;
    logic [31:0]   DMemData;
    logic [3:0]    DMemByteEn;
    logic          DMemWrEn;
    logic          DMemRdEn;
    logic [31:0]   DMemRspData;

    logic [7:0] mem     [MEM_SIZE];
    logic [7:0] ref_mem [MEM_SIZE];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    sc_lsu #(.D_MEM_SIZE(MEM_SIZE), .ADDR_W(AW)) dut (
        .Clk(Clk), .Rst_N(Rst_N),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWr(ReqWr),
        .ReqFunct3(ReqFunct3), .ReqAddr(ReqAddr), .ReqWrData(ReqWrData),
        .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspErr(RspErr),
        .DMemAddress(DMemAddress), .DMemData(DMemData), .DMemByteEn(DMemByteEn),
        .DMemWrEn(DMemWrEn), .DMemRdEn(DMemRdEn), .DMemRspData(DMemRspData)
    );

    // Data memory: little-endian bytes, combinational read, write on the edge
    assign DMemRspData = {mem[DMemAddress + AW'(3)], mem[DMemAddress + AW'(2)],
                          mem[DMemAddress + AW'(1)], mem[DMemAddress]};

    always @(posedge Clk) begin
        if (DMemWrEn) begin
            for (int i = 0; i < 4; i++) begin
                if (DMemByteEn[i]) mem[DMemAddress + AW'(i)] <= DMemData[8*i +: 8];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        @(negedge Clk);
        while (!ReqReady && w < 20) begin
            @(negedge Clk);
            w++;
        end
        chk("req_ready_wait", 32'(ReqReady), 32'd1);
    endtask

    // One full transaction, with `hold` extra cycles of response backpressure
    task automatic do_req(input logic wr, input logic [2:0] f3, input logic [AW-1:0] addr,
                          input logic [31:0] wd, input int hold);
        int unsigned size;
        bit          bad;
        logic [31:0] mask, word, val, exp_data;

        size = 1 << f3[1:0];
        bad  = (f3 == 3'd3) || (f3 >= 3'd6) || (wr && f3 >= 3'd4)
               || ((int'(addr) % size) != 0);
        mask = (size >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
        word = {ref_mem[addr + AW'(3)], ref_mem[addr + AW'(2)],
                ref_mem[addr + AW'(1)], ref_mem[addr]};
        val  = word & mask;
        exp_data = val;
        if (f3 < 3'd4 && size < 4 && val > (mask >> 1)) exp_data = val - (mask + 32'd1);
        if (bad || wr) exp_data = 32'd0;

        wait_ready();
        ReqValid  = 1'b1;
        ReqWr     = wr;
        ReqFunct3 = f3;
        ReqAddr   = addr;
        ReqWrData = wd;
        @(posedge Clk);
        @(negedge Clk);
        // Junk on the request side must be ignored while busy
        ReqValid  = 1'($urandom);
        ReqWr     = 1'($urandom);
        ReqFunct3 = 3'($urandom);
        ReqAddr   = AW'($urandom);
        ReqWrData = $urandom;
        chk("busy_ready", 32'(ReqReady), 32'd0);
        if (bad) begin
            chk("err_valid", 32'(RspValid), 32'd1);
            chk("err_flag", 32'(RspErr), 32'd1);
            chk("err_data", RspData, 32'd0);
            chk("err_wren", 32'(DMemWrEn), 32'd0);
            chk("err_rden", 32'(DMemRdEn), 32'd0);
        end else begin
            chk("acc_valid", 32'(RspValid), 32'd0);
            chk("acc_wren", 32'(DMemWrEn), 32'(wr));
            chk("acc_rden", 32'(DMemRdEn), 32'(!wr));
            chk("acc_be", 32'(DMemByteEn), (32'd1 << size) - 32'd1);
            chk("acc_wdata", DMemData, wd & mask);
            chk("acc_addr", 32'(DMemAddress), 32'(addr));
            if (wr) begin
                for (int k = 0; k < int'(size); k++) ref_mem[addr + AW'(k)] = wd[8*k +: 8];
            end
            @(negedge Clk);
            chk("rsp_valid", 32'(RspValid), 32'd1);
            chk("rsp_err", 32'(RspErr), 32'd0);
            chk("rsp_data", RspData, exp_data);
            chk("rsp_wren", 32'(DMemWrEn), 32'd0);
            chk("rsp_rden", 32'(DMemRdEn), 32'd0);
        end
        chk("rsp_addr", 32'(DMemAddress), 32'(addr));
        for (int h = 0; h < hold; h++) begin
            @(negedge Clk);
            chk("hold_valid", 32'(RspValid), 32'd1);
            chk("hold_data", RspData, exp_data);
            chk("hold_err", 32'(RspErr), 32'(bad));
            chk("hold_ready", 32'(ReqReady), 32'd0);
            chk("hold_mem", 32'({DMemWrEn, DMemRdEn}), 32'd0);
        end
        ReqValid = 1'b0;
        RspReady = 1'b1;
        @(negedge Clk);
        RspReady = 1'b0;
        chk("post_ready", 32'(ReqReady), 32'd1);
        chk("post_valid", 32'(RspValid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic        wr;
        logic [2:0]  f3;
        logic [AW-1:0] addr;
        int unsigned sz;

        for (int i = 0; i < int'(MEM_SIZE); i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        Rst_N = 1'b0; ReqValid = 1'b0; ReqWr = 1'b0; ReqFunct3 = 3'd0;
        ReqAddr = '0; ReqWrData = 32'd0; RspReady = 1'b0;
        #12;
        chk("rst_ready", 32'(ReqReady), 32'd1);
        chk("rst_valid", 32'(RspValid), 32'd0);
        chk("rst_data", RspData, 32'd0);
        chk("rst_err", 32'(RspErr), 32'd0);
        chk("rst_mem", {DMemWrEn, DMemRdEn, DMemByteEn, 26'(DMemAddress)}, 32'd0);
        chk("rst_wdata", DMemData, 32'd0);
        @(negedge Clk);
        Rst_N = 1'b1;

        // Word, byte and halfword round-trips
        do_req(1'b1, 3'b010, AW'('h10), 32'hDEADBEEF, 0);
        do_req(1'b0, 3'b010, AW'('h10), 32'd0, 0);
        chk("lw_direct", {ref_mem[16'h13], ref_mem[16'h12], ref_mem[16'h11], ref_mem[16'h10]},
            32'hDEADBEEF);
        do_req(1'b1, 3'b000, AW'('h21), 32'h1234_5680, 0);
        do_req(1'b0, 3'b000, AW'('h21), 32'd0, 0);
        do_req(1'b0, 3'b100, AW'('h21), 32'd0, 0);
        do_req(1'b1, 3'b001, AW'('h30), 32'h0000_8001, 0);
        do_req(1'b0, 3'b001, AW'('h30), 32'd0, 0);
        do_req(1'b0, 3'b101, AW'('h30), 32'd0, 0);

        // Traps
        do_req(1'b0, 3'b010, AW'('h102), 32'd0, 0);
        do_req(1'b1, 3'b001, AW'('h33), 32'h5555_AAAA, 1);
        do_req(1'b1, 3'b100, AW'('h50), 32'h1, 0);
        do_req(1'b0, 3'b011, AW'('h50), 32'd0, 0);
        do_req(1'b0, 3'b111, AW'('h54), 32'd0, 2);

        // Backpressure
        do_req(1'b0, 3'b010, AW'('h10), 32'd0, 3);

        // Reset during ACCESS of a store must suppress the write
        wait_ready();
        ReqValid = 1'b1; ReqWr = 1'b1; ReqFunct3 = 3'b010;
        ReqAddr = AW'('h40); ReqWrData = 32'h1111_1111;
        @(posedge Clk);
        #2;
        ReqValid = 1'b0;
        chk("mid_wren_before", 32'(DMemWrEn), 32'd1);
        Rst_N = 1'b0;
        #1;
        chk("mid_wren", 32'(DMemWrEn), 32'd0);
        chk("mid_rden", 32'(DMemRdEn), 32'd0);
        chk("mid_ready", 32'(ReqReady), 32'd1);
        chk("mid_valid", 32'(RspValid), 32'd0);
        chk("mid_rsp", {RspData[30:0], RspErr}, 32'd0);
        chk("mid_mem", {DMemByteEn, 28'(DMemAddress)}, 32'd0);
        chk("mid_wdata", DMemData, 32'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst_N = 1'b1;
        do_req(1'b0, 3'b010, AW'('h40), 32'd0, 0);

        // Random mix over a small window so loads hit earlier stores
        for (int n = 0; n < 200; n++) begin
            wr   = 1'($urandom);
            f3   = 3'($urandom_range(0, 7));
            addr = AW'($urandom_range(0, 255));
            sz   = 1 << f3[1:0];
            if ($urandom_range(0, 9) < 7) addr = addr & ~AW'(sz - 1);
            do_req(wr, f3, addr, $urandom, int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
